// File: rtl/conv_pkg.sv
// Shared definitions for the 1x1 convolution stages: FP32 type, constants, counter sizing.
package conv_pkg;

  localparam int FP_SIGN_BIT = 31;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam fp32_t FP_ZERO = fp32_t'(32'h0000_0000);
  localparam fp32_t FP_ONE  = fp32_t'(32'h3F80_0000);

  // Counter width for an index running 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv1x1_ch_accum_fp_add.sv
// FP_Add: combinational FP32 adder, round-to-nearest-even, subnormals kept,
// NaN quieted and propagated, Inf - Inf gives the default quiet NaN.
module FP_Add
  import conv_pkg::*;
(
  input  fp32_t data_iA,
  input  fp32_t data_iB,
  output fp32_t data_o
);

  logic        w_swap, w_sub, w_rnd;
  fp32_t       w_x, w_y;
  logic [7:0]  w_ex, w_ey, w_d;
  logic [23:0] w_mx, w_my;
  logic [4:0]  w_sh, w_lz, w_nsh;
  logic [53:0] w_al;
  logic [26:0] w_ya, w_n;
  logic [27:0] w_s;
  logic [9:0]  w_e;
  logic [24:0] w_m;

  function automatic logic [4:0] lzc(input logic [26:0] v);
    lzc = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc = 5'(26 - i);
  endfunction

  always_comb begin
    // Operand x always carries the larger magnitude, so it also owns any Inf/NaN.
    w_swap = {data_iB.exp, data_iB.man} > {data_iA.exp, data_iA.man};
    w_x    = w_swap ? data_iB : data_iA;
    w_y    = w_swap ? data_iA : data_iB;
    w_ex   = (w_x.exp == 8'd0) ? 8'd1 : w_x.exp;
    w_ey   = (w_y.exp == 8'd0) ? 8'd1 : w_y.exp;
    w_mx   = {w_x.exp != 8'd0, w_x.man};
    w_my   = {w_y.exp != 8'd0, w_y.man};
    w_d    = w_ex - w_ey;
    w_sh   = (w_d > 8'd27) ? 5'd27 : w_d[4:0];
    w_al   = {w_my, 3'b000, 27'd0} >> w_sh;
    w_ya   = {w_al[53:28], w_al[27] | (|w_al[26:0])};
    w_sub  = w_x.sign ^ w_y.sign;
    w_s    = w_sub ? ({1'b0, w_mx, 3'b000} - {1'b0, w_ya})
                   : ({1'b0, w_mx, 3'b000} + {1'b0, w_ya});
    w_e    = {2'b00, w_ex};
    w_n    = w_s[26:0];
    if (w_s[27]) begin
      w_n = {w_s[27:2], w_s[1] | w_s[0]};
      w_e = w_e + 10'd1;
    end
    // Left-normalise, but stop at the minimum exponent so results go subnormal.
    w_lz  = lzc(w_n);
    w_nsh = ({5'd0, w_lz} > (w_e - 10'd1)) ? w_e[4:0] - 5'd1 : w_lz;
    w_n   = w_n << w_nsh;
    w_e   = w_e - {5'd0, w_nsh};
    w_rnd = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
    w_m   = {1'b0, w_n[26:3]} + {24'd0, w_rnd};
    if (w_m[24]) begin
      w_m = w_m >> 1;
      w_e = w_e + 10'd1;
    end
    if (w_e >= 10'd255) data_o = {w_x.sign, 8'hFF, 23'd0};
    else                data_o = {w_x.sign, w_m[23] ? w_e[7:0] : 8'd0, w_m[22:0]};
    if (w_sub && w_n == 27'd0) data_o = FP_ZERO;
    if (w_x.exp == 8'hFF) begin
      if (w_x.man != 23'd0)                 data_o = {w_x.sign, 8'hFF, 1'b1, w_x.man[21:0]};
      else if (w_y.exp == 8'hFF && w_sub)   data_o = fp32_t'(32'h7FC0_0000);
      else                                  data_o = w_x;
    end
  end

endmodule

// File: rtl/conv1x1_ch_accum.sv
// Sums N_CH consecutive FP32 products plus a bias into one output value per group.
// Define CONV_ACCUM_RELU_EN to clamp sign-set results to +0 before they are registered.
module conv1x1_ch_accum
  import conv_pkg::*;
#(
  parameter  int                    DATA_WIDTH = 32,
  parameter  int                    N_CH       = 4,
  parameter  logic [DATA_WIDTH-1:0] BIAS       = 32'h0000_0000,
  localparam int                    CW         = cnt_w(N_CH)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  En,
  input  logic                  clear,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CW-1:0]         ch_idx
);

  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  fp32_t                 w_a, w_b, w_sum, w_res;
  logic                  w_accept, w_first, w_last;
  logic [CW-1:0]         r_ch;
  logic [DATA_WIDTH-1:0] r_acc, r_dout;
  logic                  r_vld;

  assign w_accept = valid_in & En;
  // A clear arriving with a beat restarts the group on that beat.
  assign w_first  = clear | (r_ch == '0);
  assign w_last   = (N_CH == 1) || (!clear && r_ch == LAST_CH);
  assign w_a      = w_first ? BIAS : r_acc;
  assign w_b      = data_in;

  FP_Add u_add (
    .data_iA (w_a),
    .data_iB (w_b),
    .data_o  (w_sum)
  );

`ifdef CONV_ACCUM_RELU_EN
  assign w_res = w_sum[FP_SIGN_BIT] ? FP_ZERO : w_sum;
`else
  assign w_res = w_sum;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_vld  <= 1'b0;
      r_dout <= '0;
      r_ch   <= '0;
      r_acc  <= '0;
    end else begin
      r_vld <= 1'b0;
      if (w_accept) begin
        if (w_last) begin
          r_dout <= w_res;
          r_vld  <= 1'b1;
          r_ch   <= '0;
        end else begin
          r_acc <= w_sum;
          r_ch  <= w_first ? CW'(1) : r_ch + CW'(1);
        end
      end else if (clear) begin
        r_ch <= '0;
      end
    end
  end

  assign valid_out = r_vld;
  assign data_out  = r_dout;
  assign ch_idx    = r_ch;

endmodule

// File: tb/tb_conv1x1_ch_accum.sv
// Directed bench for conv1x1_ch_accum: three configurations share one stimulus stream
// and are checked every cycle against a real-arithmetic group-sum model.
module tb_conv1x1_ch_accum;

  logic        Clk = 1'b0;
  logic        Rst, En, clear, valid_in;
  logic [31:0] data_in;
  logic        v0, v1, v2;
  logic [31:0] d0, d1, d2;
  logic [1:0]  c0, c1;
  logic        c2;

  int          n_vec = 0, n_err = 0;
  int          cyc = 0, p_last = 0, p_prev = 0;
  logic        armed = 1'b0;

  int          nch  [3] = '{4, 4, 1};
  logic [31:0] bias [3] = '{32'h0000_0000, 32'h3F00_0000, 32'h3F80_0000};
  int          cnt  [3] = '{0, 0, 0};
  real         sm   [3] = '{0.0, 0.0, 0.0};
  logic        ev   [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] ed   [3] = '{32'd0, 32'd0, 32'd0};

  always #5 Clk = ~Clk;

  conv1x1_ch_accum #(.N_CH(4), .BIAS(32'h0000_0000)) u0 (
    .Clk(Clk), .Rst(Rst), .En(En), .clear(clear), .valid_in(valid_in), .data_in(data_in),
    .valid_out(v0), .data_out(d0), .ch_idx(c0));
  conv1x1_ch_accum #(.N_CH(4), .BIAS(32'h3F00_0000)) u1 (
    .Clk(Clk), .Rst(Rst), .En(En), .clear(clear), .valid_in(valid_in), .data_in(data_in),
    .valid_out(v1), .data_out(d1), .ch_idx(c1));
  conv1x1_ch_accum #(.N_CH(1), .BIAS(32'h3F80_0000)) u2 (
    .Clk(Clk), .Rst(Rst), .En(En), .clear(clear), .valid_in(valid_in), .data_in(data_in),
    .valid_out(v2), .data_out(d2), .ch_idx(c2));

  // Stimulus uses only normal values whose sums are exact in FP32.
  function automatic real f2r(input logic [31:0] f);
    real m;
    int  e;
    if (f[30:0] == 31'd0) return 0.0;
    m = 1.0 + $itor({9'd0, f[22:0]}) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic s;
    int   e;
    real  m;
    if (r == 0.0) return 32'd0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  function automatic logic [31:0] post(input logic [31:0] f);
`ifdef CONV_ACCUM_RELU_EN
    return f[31] ? 32'd0 : f;
`else
    return f;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Apply one cycle of inputs, advance the model to what the coming edge must produce.
  task automatic step(input logic r, input logic v, input logic e, input logic c,
                      input logic [31:0] d);
    Rst = r; valid_in = v; En = e; clear = c; data_in = d;
    if (!r) armed = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ev[k] = 1'b0;
      if (!r) begin
        cnt[k] = 0; sm[k] = 0.0; ed[k] = 32'd0;
      end else begin
        if (c) begin cnt[k] = 0; sm[k] = 0.0; end
        if (v && e) begin
          sm[k]  = sm[k] + f2r(d);
          cnt[k] = cnt[k] + 1;
          if (cnt[k] == nch[k]) begin
            ed[k]  = post(r2f(f2r(bias[k]) + sm[k]));
            ev[k]  = 1'b1;
            cnt[k] = 0;
            sm[k]  = 0.0;
          end
        end
      end
    end
    @(negedge Clk);
  endtask

  always @(posedge Clk) begin
    #1;
    if (armed) begin
      cyc++;
      chk("u0.valid_out", 32'(v0), 32'(ev[0]));
      chk("u0.data_out",  d0,      ed[0]);
      chk("u0.ch_idx",    32'(c0), 32'(cnt[0]));
      chk("u1.valid_out", 32'(v1), 32'(ev[1]));
      chk("u1.data_out",  d1,      ed[1]);
      chk("u1.ch_idx",    32'(c1), 32'(cnt[1]));
      chk("u2.valid_out", 32'(v2), 32'(ev[2]));
      chk("u2.data_out",  d2,      ed[2]);
      chk("u2.ch_idx",    32'(c2), 32'(cnt[2]));
      if (v1) begin p_prev = p_last; p_last = cyc; end
    end
  end

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h3F80_0000);
    chk("rst.valid", 32'(v0), 32'd0);
    chk("rst.data",  d0,      32'd0);
    chk("rst.ch",    32'(c0), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);

    // 1+2+3+4, then the same group back to back
    for (int g = 0; g < 2; g++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h3F80_0000);
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4000_0000);
      chk("nch1.data",  d2,      32'h4040_0000);
      chk("nch1.valid", 32'(v2), 32'd1);
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4040_0000);
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4080_0000);
      chk("sum10.valid", 32'(v0), 32'd1);
      chk("sum10.data",  d0,      32'h4120_0000);
      chk("bias.data",   d1,      32'h4128_0000);
    end
    chk("spacing", 32'(p_last - p_prev), 32'd4);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    chk("pulse1cyc", 32'(v0), 32'd0);

    // negative group
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'hBF80_0000);
`ifdef CONV_ACCUM_RELU_EN
    chk("neg.data", d0, 32'h0000_0000);
`else
    chk("neg.data", d0, 32'hC080_0000);
`endif

    // stall with En low while valid_in stays high
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h3F80_0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4000_0000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h40A0_0000);
    chk("stall.ch", 32'(c0), 32'd2);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4040_0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4080_0000);
    chk("stall.data", d0, 32'h4120_0000);

    // clear alone mid-group, then a fresh 1+2+3+5
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4100_0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4100_0000);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'd0);
    chk("clear.ch", 32'(c0), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h3F80_0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4000_0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4040_0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h40A0_0000);
    chk("clear.data", d0, 32'h4130_0000);

    // clear together with a beat: 1+2+3+2
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4100_0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4100_0000);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h3F80_0000);
    chk("clrbeat.ch", 32'(c0), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4000_0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4040_0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4000_0000);
    chk("clrbeat.data",  d0, 32'h4100_0000);
    chk("clrbeat.bias",  d1, 32'h4108_0000);

    // reset after three beats
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h3F80_0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4000_0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4040_0000);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h4080_0000);
    chk("midrst.valid", 32'(v0), 32'd0);
    chk("midrst.data",  d0,      32'd0);
    chk("midrst.ch",    32'(c0), 32'd0);
    chk("midrst.nch1",  d2,      32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h3F80_0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4000_0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4040_0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4080_0000);
    chk("postrst.data", d0, 32'h4120_0000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
